pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pa_pkg.sv | 16 +
 rtl/pipe_skid_ctrl.sv | 92 +++++++++
 rtl/pipe_skid_reg.sv | 65 ++++++
 tb/tb_pipe_skid_reg.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// pa_pkg -- shared types and constants for the two-entry pipeline skid register.
//   skid_state_t : occupancy state (EMPTY / ONE / FULL), encoding equals entry count
//   SKID_DEPTH   : number of entries the block can hold
//   CNT_W        : width of the occupancy count output
package pa_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl -- occupancy state machine for pipe_skid_reg.
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid        : producer offers data
//   out_ready       : consumer takes data
//   flush           : synchronous discard of all held entries
//   in_ready        : block can accept (decoded from state flops only)
//   out_valid       : main register holds a valid entry
//   count           : number of held entries (0..2)
//   main_load       : load the main register this cycle
//   main_sel_skid   : main register loads from skid (1) or in_data (0)
//   skid_load       : load the skid register from in_data this cycle
module pipe_skid_ctrl
  import pa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             main_load,
  output logic             main_sel_skid,
  output logic             skid_load
);

  skid_state_t state_q, state_d;
  logic        push, pop;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state logic; flush overrides any push or pop in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (!push && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs and data-path load enables. Data registers keep their contents
  // on flush, so no load is issued in a flush cycle.
  always_comb begin
    in_ready      = 1'b1;
    out_valid     = 1'b0;
    count         = '0;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        main_load = push & ~flush;
      end
      ONE: begin
        out_valid = 1'b1;
        count     = CNT_W'(1);
        // Simultaneous push and pop refreshes main directly from in_data.
        main_load = push & pop & ~flush;
        skid_load = push & ~pop & ~flush;
      end
      FULL: begin
        in_ready      = 1'b0;
        out_valid     = 1'b1;
        count         = CNT_W'(2);
        main_load     = pop & ~flush;
        main_sel_skid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- two-entry valid/ready pipeline register with skid buffer.
// in_ready depends only on flops, breaking the combinational ready path.
//   LENGTH    : data width
//   clk, reset: clock, asynchronous active-low reset
//   in_valid/in_data/in_ready    : producer handshake
//   out_valid/out_data/out_ready : consumer handshake (out_data = main register)
//   flush     : discard all held entries (data registers keep values)
//   count     : number of held entries (0..2)
module pipe_skid_reg
  import pa_pkg::*;
#(
  parameter int LENGTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [LENGTH-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  logic              main_load, main_sel_skid, skid_load;
  logic [LENGTH-1:0] main_q, main_d;
  logic [LENGTH-1:0] skid_q, skid_d;

  pipe_skid_ctrl u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .flush         (flush),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .count         (count),
    .main_load     (main_load),
    .main_sel_skid (main_sel_skid),
    .skid_load     (skid_load)
  );

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (main_load) main_d = main_sel_skid ? skid_q : in_data;
    if (skid_load) skid_d = in_data;
  end

  // NOTE: the data registers are reset on purpose so out_data reads 0
  // after reset; they are two plain registers, not a memory array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg -- self-checking bench for pipe_skid_reg (LENGTH=8).
// A queue-based model (at most two entries, FIFO order) predicts all outputs
// and is compared every falling edge; directed steps add literal checks.
module tb_pipe_skid_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [1:0]   count;

  int vec_count  = 0;
  int miss_count = 0;

  pipe_skid_reg #(.LENGTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of held entries plus the last value presented.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_last = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      bit pu, po;
      pu = in_valid && (mq.size() < 2);
      po = (mq.size() > 0) && out_ready;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge clk) begin
    check("model_count",     32'(count),     32'(mq.size()));
    check("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("model_in_ready",  32'(in_ready),  32'(mq.size() < 2));
    check("model_out_data",  32'(out_data),  32'(m_last));
    check("ready_when_full", 32'(in_ready && count == 2'd2), 32'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string tag, input logic v, input logic [1:0] c,
                     input logic r, input logic [W-1:0] d);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_count"},     32'(count),     32'(c));
    check({tag, "_in_ready"},  32'(in_ready),  32'(r));
    check({tag, "_out_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #3;
    pin("reset", 1'b0, 2'd0, 1'b1, 8'h00);
    #9;                     // t=12, between edges
    reset = 1'b1;

    // Single push, first edge after reset.
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    step();
    pin("first_push", 1'b1, 2'd1, 1'b1, 8'h11);
    in_valid = 1'b0;
    step();
    pin("first_pop", 1'b0, 2'd0, 1'b1, 8'h11);

    // Back-pressure: fill, block third, drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    pin("full", 1'b1, 2'd2, 1'b0, 8'hA1);
    in_data = 8'hA3; step();
    pin("full_blocked", 1'b1, 2'd2, 1'b0, 8'hA1);
    out_ready = 1'b1; step();
    pin("pop_a1", 1'b1, 2'd1, 1'b1, 8'hA2);
    step();
    pin("pop_a2_push_a3", 1'b1, 2'd1, 1'b1, 8'hA3);
    in_valid = 1'b0; step();
    pin("drain_a3", 1'b0, 2'd0, 1'b1, 8'hA3);

    // Streaming: one in, one out per cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = W'(i);
      step();
      pin("stream", 1'b1, 2'd1, 1'b1, W'(i));
    end
    in_valid = 1'b0; step();

    // Flush from FULL with a concurrent push that must be discarded.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1; step();
    in_data = 8'hB2; step();
    flush = 1'b1; in_data = 8'hB3; step();
    pin("flush", 1'b0, 2'd0, 1'b1, 8'hB1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    pin("after_flush", 1'b0, 2'd0, 1'b1, 8'hB1);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1; step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    pin("async_reset", 1'b0, 2'd0, 1'b1, 8'h00);
    step();
    reset = 1'b1;
    in_valid = 1'b1; in_data = 8'hC2; out_ready = 1'b1; step();
    pin("post_reset_push", 1'b1, 2'd1, 1'b1, 8'hC2);
    in_valid = 1'b0; step();
    pin("post_reset_drain", 1'b0, 2'd0, 1'b1, 8'hC2);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = W'($urandom);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    pin("final_drain", 1'b0, 2'd0, 1'b1, m_last);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
